// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity mode encodings
//   tx_state_e                    : transmitter FSM state encoding
//   params_ok()                   : parameter legality check used at elaboration
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic bit params_ok(input int data_w, input int stop_bits, input int parity);
        return (data_w >= 5) && (data_w <= 9) &&
               (stop_bits == 1 || stop_bits == 2) &&
               (parity >= PAR_NONE) && (parity <= PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Single-clock FIFO feeding the UART transmitter.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_push, i_data   : write request and data
//   i_pop            : read request (ignored while empty)
//   o_head           : word at the head of the queue
//   o_full, o_empty  : registered occupancy flags
//   o_empty_nxt      : value o_empty takes at the next edge
//   o_ovf            : one-cycle pulse after a dropped write
//   o_level          : occupancy, 0 .. 2^AW
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_empty_nxt,
    output logic             o_ovf,
    output logic [AW:0]      o_level
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop  = i_pop & ~empty_q;
        // A pop in the same cycle frees a slot, so a write to a full FIFO is still taken.
        do_push = i_push & (~full_q | do_pop);
        ovf_d   = i_push & full_q & ~do_pop;

        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + AW'(1);
        if (do_pop)  rptr_d = rptr_q + AW'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);

        full_d  = (cnt_d == (AW+1)'(DEPTH));
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wptr_q] <= i_data;
    end

    assign o_head      = mem_q[rptr_q];
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_empty_nxt = empty_d;
    assign o_ovf       = ovf_q;
    assign o_level     = cnt_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO, runtime baud divisor, configurable
// data width, parity and stop bits. Frames go out back-to-back while the
// FIFO holds data.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_div          : bit period minus one, latched at each frame start
//   i_data, i_wr   : character and write strobe
//   o_full, o_ovf  : FIFO full, dropped-write pulse
//   o_level        : FIFO occupancy
//   o_busy         : frame in progress
//   o_txempty      : FIFO empty and line idle
//   o_uart_tx      : serial output, idle high
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DIV_WID   = 16,
    parameter int DATA_W    = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [DIV_WID-1:0] i_div,
    input  logic [DATA_W-1:0]  i_data,
    input  logic               i_wr,
    output logic               o_full,
    output logic               o_ovf,
    output logic [FIFO_AW:0]   o_level,
    output logic               o_busy,
    output logic               o_txempty,
    output logic               o_uart_tx
);

    if (!params_ok(DATA_W, STOP_BITS, PARITY)) begin : g_bad_params
        $error("uart_tx_fifo: DATA_W must be 5..9, STOP_BITS 1 or 2, PARITY 0..2");
    end

    localparam int MAXB = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int BCW  = (MAXB > 1) ? $clog2(MAXB) : 1;

    function automatic logic calc_parity(input logic [DATA_W-1:0] w);
        return (PARITY == PAR_ODD) ? ~^w : ^w;
    endfunction

    tx_state_e          state_q, state_d;
    logic [DIV_WID-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_WID-1:0] div_lat_q, div_lat_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               txempty_q;

    logic [DATA_W-1:0]  fifo_head;
    logic               fifo_empty, fifo_empty_nxt;
    logic               pop, start_frame, bit_end;

    uart_fifo #(
        .WIDTH (DATA_W),
        .AW    (FIFO_AW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (i_wr),
        .i_data      (i_data),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (o_full),
        .o_empty     (fifo_empty),
        .o_empty_nxt (fifo_empty_nxt),
        .o_ovf       (o_ovf),
        .o_level     (o_level)
    );

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        div_lat_d   = div_lat_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        pop         = 1'b0;
        start_frame = 1'b0;
        bit_end     = (div_cnt_q == '0);

        // Within a frame the divisor counter either counts down or reloads
        // for the next bit; the state cases below override the reload.
        if (state_q != ST_IDLE && !bit_end) div_cnt_d = div_cnt_q - DIV_WID'(1);
        else if (state_q != ST_IDLE)        div_cnt_d = div_lat_q;

        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) start_frame = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = BCW'(DATA_W - 1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q != '0) begin
                        tx_d      = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end else if (PARITY != PAR_NONE) begin
                        state_d = ST_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d   = ST_STOP;
                        tx_d      = 1'b1;
                        bit_cnt_d = BCW'(STOP_BITS - 1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    tx_d      = 1'b1;
                    bit_cnt_d = BCW'(STOP_BITS - 1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - BCW'(1);
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame start: pop the head, compute its parity once, and latch the
        // divisor so mid-frame i_div changes only affect later frames.
        if (start_frame) begin
            pop       = 1'b1;
            state_d   = ST_START;
            div_lat_d = i_div;
            div_cnt_d = i_div;
            shreg_d   = fifo_head;
            par_d     = calc_parity(fifo_head);
            tx_d      = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            txempty_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            // Registered from next-state values so it lines up with o_busy/o_level.
            txempty_q <= ~busy_d & fifo_empty_nxt;
        end
    end

    assign o_uart_tx = tx_q;
    assign o_busy    = busy_q;
    assign o_txempty = txempty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

    localparam int NI = 2;   // instance 0: even parity, 1 stop; instance 1: odd parity, 2 stops

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         dv;
        bit         b2b;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NI-1:0] rst_n;
    logic [NI-1:0] wr;
    logic [15:0]   div  [NI];
    logic [7:0]    data [NI];
    wire  [NI-1:0] full, ovf, busy, txempty, tx;
    wire  [2:0]    level [NI];

    bit   [NI-1:0] mon_en;
    exp_t          exp_q0[$];
    exp_t          exp_q1[$];
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int PAR   = (g == 0) ? 2 : 1;
        localparam int NSTOP = (g == 0) ? 1 : 2;

        uart_tx_fifo #(
            .DIV_WID   (16),
            .DATA_W    (8),
            .PARITY    (PAR),
            .STOP_BITS (NSTOP),
            .FIFO_AW   (2)
        ) u_dut (
            .i_clk     (clk),
            .i_rst_n   (rst_n[g]),
            .i_div     (div[g]),
            .i_data    (data[g]),
            .i_wr      (wr[g]),
            .o_full    (full[g]),
            .o_ovf     (ovf[g]),
            .o_level   (level[g]),
            .o_busy    (busy[g]),
            .o_txempty (txempty[g]),
            .o_uart_tx (tx[g])
        );

        // Monitor: decodes frames off the line and compares them with the queue.
        initial begin : mon
            exp_t        e;
            logic [11:0] bits;
            int          nb, last_end, n;
            bit          ok, abort;
            last_end = -100;
            forever begin
                @(negedge clk);
                if (mon_en[g] && rst_n[g] && tx[g] === 1'b0) begin
                    if (qsize(g) == 0) begin
                        check($sformatf("i%0d_frame_queued", g), 32'(qsize(g)), 32'd1);
                        n = 0;
                        while (tx[g] === 1'b0 && n < 2000) begin @(negedge clk); n++; end
                    end else begin
                        if (g == 0) e = exp_q0.pop_front(); else e = exp_q1.pop_front();
                        if (e.b2b) check($sformatf("i%0d_%02h_gap", g, e.d), 32'(cyc - last_end), 32'd1);
                        bits    = '1;
                        bits[0] = 1'b0;
                        for (int i = 0; i < 8; i++) bits[1+i] = e.d[i];
                        bits[9] = e.p;
                        nb      = 10 + NSTOP;
                        abort   = 1'b0;
                        for (int j = 0; j < nb && !abort; j++) begin
                            ok = 1'b1;
                            for (int c = 0; c <= e.dv; c++) begin
                                if (!(j == 0 && c == 0)) @(negedge clk);
                                if (!rst_n[g]) begin abort = 1'b1; break; end
                                if (tx[g] !== bits[j]) ok = 1'b0;
                            end
                            if (!abort) check($sformatf("i%0d_%02h_bit%0d", g, e.d, j), 32'(ok), 32'd1);
                        end
                        last_end = cyc;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cycle(input int i, input logic [7:0] d);
        wr[i]   = 1'b1;
        data[i] = d;
        tick();
        wr[i]   = 1'b0;
    endtask

    task automatic push(input int i, input logic [7:0] d, input logic p, input int dv, input bit b2b);
        exp_t e;
        e.d = d; e.p = p; e.dv = dv; e.b2b = b2b;
        if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    endtask

    task automatic drain(input int i, input int budget);
        int n;
        n = 0;
        while (!(txempty[i] && qsize(i) == 0) && n < budget) begin tick(); n++; end
        check($sformatf("i%0d_drain_in_time", i), 32'(n < budget), 32'd1);
        check($sformatf("i%0d_txempty_idle", i), 32'(txempty[i]), 32'd1);
    endtask

    // Call right after the pop edge; counts edges until o_txempty returns.
    task automatic frame_len(input int i, input int req);
        int n;
        n = 0;
        while (!txempty[i] && n < 500) begin tick(); n++; end
        check($sformatf("i%0d_frame_len", i), 32'(n), 32'(req));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : main
        logic [7:0] bw [6];
        logic       bp [4];
        bit         ok;
        bw = '{8'h3C, 8'hFF, 8'h80, 8'h7E, 8'h55, 8'h66};
        bp = '{1'b0, 1'b0, 1'b1, 1'b0};

        rst_n  = '0;
        wr     = '0;
        mon_en = '1;
        div[0] = 16'd3;  data[0] = '0;
        div[1] = 16'd0;  data[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = '1;
        tick();

        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d_rst_tx", i),      32'(tx[i]),      32'd1);
            check($sformatf("i%0d_rst_busy", i),    32'(busy[i]),    32'd0);
            check($sformatf("i%0d_rst_txempty", i), 32'(txempty[i]), 32'd1);
            check($sformatf("i%0d_rst_full", i),    32'(full[i]),    32'd0);
            check($sformatf("i%0d_rst_ovf", i),     32'(ovf[i]),     32'd0);
            check($sformatf("i%0d_rst_level", i),   32'(level[i]),   32'd0);
        end

        // Basic frame 0xA5, even parity (four ones -> 0), 4-cycle bits.
        push(0, 8'hA5, 1'b0, 3, 1'b0);
        wr_cycle(0, 8'hA5);
        check("lat_level_k",   32'(level[0]),   32'd1);
        check("lat_tx_k",      32'(tx[0]),      32'd1);
        check("lat_txempty_k", 32'(txempty[0]), 32'd0);
        tick();
        check("lat_level_k1",  32'(level[0]),   32'd0);
        check("lat_tx_k1",     32'(tx[0]),      32'd0);
        check("lat_busy_k1",   32'(busy[0]),    32'd1);
        frame_len(0, 44);
        drain(0, 100);

        // Odd parity, two stops, 1-cycle bits: 0x07 has three ones -> parity 0.
        push(1, 8'h07, 1'b0, 0, 1'b0);
        wr_cycle(1, 8'h07);
        tick();
        check("odd_tx_start", 32'(tx[1]), 32'd0);
        frame_len(1, 12);
        drain(1, 50);

        // Burst while busy: four accepted, two dropped.
        push(0, 8'h01, 1'b1, 3, 1'b0);
        wr_cycle(0, 8'h01);
        tick();
        check("burst_busy", 32'(busy[0]), 32'd1);
        for (int i = 0; i < 6; i++) begin
            if (i < 4) push(0, bw[i], bp[i], 3, 1'b1);
            wr_cycle(0, bw[i]);
            check($sformatf("burst_full_%0d", i),  32'(full[0]),  32'(i >= 3));
            check($sformatf("burst_ovf_%0d", i),   32'(ovf[0]),   32'(i >= 4));
            check($sformatf("burst_level_%0d", i), 32'(level[0]), 32'((i < 4) ? i + 1 : 4));
        end
        // Write lands on the edge that ends 0x01's stop bit and pops the next word.
        repeat (37) tick();
        push(0, 8'hC3, 1'b0, 3, 1'b1);
        wr_cycle(0, 8'hC3);
        check("popwr_ovf",   32'(ovf[0]),   32'd0);
        check("popwr_level", 32'(level[0]), 32'd4);
        check("popwr_full",  32'(full[0]),  32'd1);
        drain(0, 400);

        // Divisor change mid-frame: 0x5A keeps 4-cycle bits, 0x0F uses 10.
        push(0, 8'h5A, 1'b0, 3, 1'b0);
        wr_cycle(0, 8'h5A);
        tick();
        div[0] = 16'd9;
        push(0, 8'h0F, 1'b0, 9, 1'b1);
        wr_cycle(0, 8'h0F);
        drain(0, 300);

        // Reset during data bit 0 of 0x32 (bit 0 is a zero).
        mon_en[0] = 1'b0;
        wr_cycle(0, 8'h32);
        tick();
        repeat (15) tick();
        check("prerst_tx", 32'(tx[0]), 32'd0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("rst_async_tx",    32'(tx[0]),      32'd1);
        check("rst_async_level", 32'(level[0]),   32'd0);
        check("rst_async_busy",  32'(busy[0]),    32'd0);
        check("rst_async_empty", 32'(txempty[0]), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n[0] = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (tx[0] !== 1'b1 || level[0] !== 3'd0 || busy[0] !== 1'b0) ok = 1'b0;
        end
        check("idle_after_reset", 32'(ok), 32'd1);
        mon_en[0] = 1'b1;
        push(0, 8'h81, 1'b0, 9, 1'b0);
        wr_cycle(0, 8'h81);
        drain(0, 300);

        check("i0_queue_left", 32'(qsize(0)), 32'd0);
        check("i1_queue_left", 32'(qsize(1)), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
